router_pkt_tx: RTL and testbench
================================

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: start  in  1  request one packet; sampled only when ready=1 and busy=0.
REQ-004 SHALL have: dest_addr  in  2  destination port 0..2; 3 is illegal.
REQ-005 SHALL have: pay_len  in  6  payload byte count 1..63; 0 is illegal.
REQ-006 SHALL have: seed  in  8  LFSR payload seed, captured with start.
REQ-007 SHALL have: busy  in  1  router backpressure (FIFO full); freezes the transmitter.
REQ-008 SHALL have: dout  out  8  byte to router input; pkt_vld  out  1  high for header and payload bytes only.
REQ-009 SHALL have: ready  out  1  high in IDLE; done  out  1  one-cycle pulse after parity byte; err  out  1  one-cycle pulse on illegal request; pkt_cnt  out  8  sent-packet count.

Function
REQ-010 SHALL implement FSM IDLE -> HEADER -> PAYLOAD -> PARITY -> GAP -> IDLE; all outputs registered.
REQ-011 IDLE: start=1, busy=0, legal request -> capture addr/len/seed, go to HEADER next edge; start outside IDLE ignored.
REQ-012 Illegal request (dest_addr=3 or pay_len=0) SHALL stay in IDLE, pulse err one cycle, keep pkt_vld=0.
REQ-013 HEADER: dout={pay_len,dest_addr}, pkt_vld=1; parity accumulator initialised to header byte.
REQ-014 PAYLOAD: pay_len bytes, pkt_vld=1; byte k = LFSR value k, LFSR starts at seed (seed 0 replaced by 8'h01); step next={l[6:0], l[7]^l[5]^l[4]^l[3]}.
REQ-015 Each sent byte SHALL be XORed into parity; byte counter 6 bits, leaves PAYLOAD after byte pay_len.
REQ-016 PARITY: dout=parity, pkt_vld=0, exactly one cycle (excluding stall).
REQ-017 GAP: dout=0, pkt_vld=0 one cycle; done pulses and pkt_cnt increments (wraps 255->0) on GAP entry.
REQ-018 busy=1 at an edge in HEADER/PAYLOAD/PARITY SHALL hold state, dout, pkt_vld, counter, LFSR and parity unchanged; no byte dropped or repeated.
REQ-019 Latency: start accepted at edge N -> header visible after edge N+1; total packet = pay_len+4 cycles with busy=0.
REQ-020 Back-to-back: start held high SHALL begin next packet the cycle after return to IDLE.

Reset
REQ-021 rst=1 at an edge SHALL force IDLE, dout=0, pkt_vld=0, done=0, err=0, pkt_cnt=0, ready=1, internal regs 0, regardless of state (mid-packet abort, no parity emitted).
REQ-022 rst SHALL take priority over start and busy.

Configuration
REQ-023 Macro ROUTER_PKT_TX_PAR_INJ_EN defined: extra input par_inj (1 bit), captured with start; if set, parity byte bit 0 inverted for that packet.
REQ-024 Macro undefined: no par_inj port, parity always correct.

Verification
REQ-025 addr=2, len=14, seed=8'hA5 -> 8'h3A header, 14 LFSR bytes from A5, XOR parity with pkt_vld=0, done, pkt_cnt=1.
REQ-026 addr=0, len=1, seed=8'h00 -> 04, 01 (pkt_vld=1), parity 05 (pkt_vld=0), total 5 cycles.
REQ-027 busy high 3 cycles during payload byte 5 -> dout frozen 3 extra cycles, full stream otherwise identical to REQ-025.
REQ-028 start with addr=3 or len=0 -> err pulse, pkt_vld stays 0, ready stays 1, pkt_cnt unchanged.
REQ-029 rst asserted at payload byte 7 -> next cycle dout=0, pkt_vld=0, ready=1, pkt_cnt=0; new packet afterwards correct.
REQ-030 With ROUTER_PKT_TX_PAR_INJ_EN, par_inj=1 on REQ-026 packet -> parity byte 04; without macro -> 05.

Source files
------------

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: header, LFSR payload, XOR parity byte, one gap cycle.
// Optional parity-error injection enabled by defining ROUTER_PKT_TX_PAR_INJ_EN.
module router_pkt_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic [5:0] pay_len,
    input  logic [7:0] seed,
    input  logic       busy,
`ifdef ROUTER_PKT_TX_PAR_INJ_EN
    input  logic       par_inj,
`endif
    output logic [7:0] dout,
    output logic       pkt_vld,
    output logic       ready,
    output logic       done,
    output logic       err,
    output logic [7:0] pkt_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEADER  = 3'd1,
        PAYLOAD = 3'd2,
        PARITY  = 3'd3,
        GAP     = 3'd4
    } state_t;

    state_t     state;
    logic [1:0] addr_q;
    logic [5:0] len_q;
    logic [5:0] byte_cnt;
    logic [7:0] lfsr;
    logic [7:0] parity;
`ifdef ROUTER_PKT_TX_PAR_INJ_EN
    logic       inj_q;
`endif

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            byte_cnt <= '0;
            lfsr     <= '0;
            parity   <= '0;
`ifdef ROUTER_PKT_TX_PAR_INJ_EN
            inj_q    <= 1'b0;
`endif
            dout     <= '0;
            pkt_vld  <= 1'b0;
            ready    <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            pkt_cnt  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !busy) begin
                        if (dest_addr == 2'd3 || pay_len == 6'd0) begin
                            err <= 1'b1;
                        end else begin
                            addr_q   <= dest_addr;
                            len_q    <= pay_len;
                            lfsr     <= (seed == 8'h00) ? 8'h01 : seed;
                            byte_cnt <= '0;
`ifdef ROUTER_PKT_TX_PAR_INJ_EN
                            inj_q    <= par_inj;
`endif
                            ready    <= 1'b0;
                            state    <= HEADER;
                        end
                    end
                end
                // Stalled states simply skip the update, so every register holds.
                HEADER: begin
                    if (!busy) begin
                        dout    <= {len_q, addr_q};
                        pkt_vld <= 1'b1;
                        parity  <= {len_q, addr_q};
                        state   <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (!busy) begin
                        dout     <= lfsr;
                        pkt_vld  <= 1'b1;
                        parity   <= parity ^ lfsr;
                        lfsr     <= lfsr_next(lfsr);
                        byte_cnt <= byte_cnt + 6'd1;
                        if (byte_cnt + 6'd1 == len_q)
                            state <= PARITY;
                    end
                end
                PARITY: begin
                    if (!busy) begin
`ifdef ROUTER_PKT_TX_PAR_INJ_EN
                        dout <= parity ^ {7'b0, inj_q};
`else
                        dout <= parity;
`endif
                        pkt_vld <= 1'b0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    dout    <= '0;
                    pkt_vld <= 1'b0;
                    done    <= 1'b1;
                    pkt_cnt <= pkt_cnt + 8'd1;
                    ready   <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx with an expected-byte scoreboard queue.
module tb_router_pkt_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] pay_len;
    logic [7:0] seed;
    logic       busy;
    logic       par_inj;
    logic [7:0] dout;
    logic       pkt_vld;
    logic       ready;
    logic       done;
    logic       err;
    logic [7:0] pkt_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_cnt = 8'd0;

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic       dn;
    } exp_t;
    exp_t sbq[$];

`ifdef ROUTER_PKT_TX_PAR_INJ_EN
    localparam logic INJ_ON = 1'b1;
`else
    localparam logic INJ_ON = 1'b0;
`endif

    router_pkt_tx dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dest_addr (dest_addr),
        .pay_len   (pay_len),
        .seed      (seed),
        .busy      (busy),
`ifdef ROUTER_PKT_TX_PAR_INJ_EN
        .par_inj   (par_inj),
`endif
        .dout      (dout),
        .pkt_vld   (pkt_vld),
        .ready     (ready),
        .done      (done),
        .err       (err),
        .pkt_cnt   (pkt_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Feedback taps 7,5,4,3 expressed as a parity mask.
    function automatic logic [7:0] model_step(input logic [7:0] l);
        return (l << 1) | {7'b0, ^(l & 8'hB8)};
    endfunction

    task automatic run_pkt(input logic [1:0] a, input logic [5:0] l, input logic [7:0] s,
                           input logic inj, input int stall_at, input int stall_len,
                           input int abort_at, input bit keep);
        logic [7:0] lf;
        logic [7:0] par;
        exp_t e;
        int idx;
        sbq.push_back('{d: {l, a}, v: 1'b1, dn: 1'b0});
        par = {l, a};
        lf = (s == 8'h00) ? 8'h01 : s;
        for (int k = 0; k < int'(l); k++) begin
            sbq.push_back('{d: lf, v: 1'b1, dn: 1'b0});
            par = par ^ lf;
            lf = model_step(lf);
        end
        sbq.push_back('{d: par ^ {7'b0, inj & INJ_ON}, v: 1'b0, dn: 1'b0});
        sbq.push_back('{d: 8'h00, v: 1'b0, dn: 1'b1});

        start = 1'b1; dest_addr = a; pay_len = l; seed = s; par_inj = inj;
        @(negedge clk);
        if (!keep) start = 1'b0;
        chk("lat_ready", {7'b0, ready}, 8'd0);
        chk("lat_vld", {7'b0, pkt_vld}, 8'd0);
        @(negedge clk);
        idx = 0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk($sformatf("dout[%0d]", idx), dout, e.d);
            chk($sformatf("vld[%0d]", idx), {7'b0, pkt_vld}, {7'b0, e.v});
            chk($sformatf("done[%0d]", idx), {7'b0, done}, {7'b0, e.dn});
            if (idx == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                start = 1'b0;
                chk("abort_dout", dout, 8'h00);
                chk("abort_vld", {7'b0, pkt_vld}, 8'd0);
                chk("abort_ready", {7'b0, ready}, 8'd1);
                chk("abort_cnt", pkt_cnt, 8'd0);
                exp_cnt = 8'd0;
                sbq.delete();
                return;
            end
            if (idx == stall_at) begin
                busy = 1'b1;
                repeat (stall_len) begin
                    @(negedge clk);
                    chk("stall_dout", dout, e.d);
                    chk("stall_vld", {7'b0, pkt_vld}, {7'b0, e.v});
                end
                busy = 1'b0;
            end
            if (sbq.size() > 0) @(negedge clk);
            idx++;
        end
        exp_cnt = exp_cnt + 8'd1;
        chk("pkt_cnt", pkt_cnt, exp_cnt);
        chk("ready_end", {7'b0, ready}, 8'd1);
    endtask

    task automatic illegal_req(input logic [1:0] a, input logic [5:0] l);
        start = 1'b1; dest_addr = a; pay_len = l; seed = 8'h11; par_inj = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("ill_err", {7'b0, err}, 8'd1);
        chk("ill_vld", {7'b0, pkt_vld}, 8'd0);
        chk("ill_ready", {7'b0, ready}, 8'd1);
        chk("ill_cnt", pkt_cnt, exp_cnt);
        @(negedge clk);
        chk("ill_err_clr", {7'b0, err}, 8'd0);
        chk("ill_ready2", {7'b0, ready}, 8'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dest_addr = '0; pay_len = '0; seed = '0;
        busy = 1'b0; par_inj = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_dout", dout, 8'h00);
        chk("rst_vld", {7'b0, pkt_vld}, 8'd0);
        chk("rst_ready", {7'b0, ready}, 8'd1);
        chk("rst_done", {7'b0, done}, 8'd0);
        chk("rst_err", {7'b0, err}, 8'd0);
        chk("rst_cnt", pkt_cnt, 8'd0);
        @(negedge clk);

        run_pkt(2'd2, 6'd14, 8'hA5, 1'b0, -1, 0, -1, 1'b0);
        run_pkt(2'd0, 6'd1, 8'h00, 1'b0, -1, 0, -1, 1'b0);
        run_pkt(2'd2, 6'd14, 8'hA5, 1'b0, 5, 3, -1, 1'b0);
        illegal_req(2'd3, 6'd5);
        illegal_req(2'd1, 6'd0);
        run_pkt(2'd1, 6'd63, 8'h3C, 1'b0, 0, 2, -1, 1'b0);
        run_pkt(2'd1, 6'd20, 8'h77, 1'b0, -1, 0, 7, 1'b0);
        @(negedge clk);
        run_pkt(2'd0, 6'd3, 8'hFF, 1'b0, -1, 0, -1, 1'b0);
        run_pkt(2'd1, 6'd2, 8'h5A, 1'b0, 2, 2, -1, 1'b1);
        run_pkt(2'd2, 6'd4, 8'h81, 1'b0, -1, 0, -1, 1'b0);
        run_pkt(2'd0, 6'd1, 8'h00, 1'b1, -1, 0, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
